// File: rtl/alu_pkg.sv
// Package shared by the decode stage and the sequential ALU.
// Holds the 4-bit opcode encoding, the ALU FSM state encoding and a
// small helper that tells whether an opcode belongs to the encoding table.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR: is_legal_op = 1'b1;
         default:                                        is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Interface bundling the request and response sides of seq_alu.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. The request side (in_valid/in_ready) carries opcode
// and both operands. The response side (out_valid/out_ready) carries
// result, result_hi and flags. While valid is 1 and ready is 0, the
// sender holds its payload stable.
//
// master: processor side (drives requests, accepts responses).
// slave : ALU side (accepts requests, drives responses and dbg_state).
interface seq_alu_if #(parameter int WIDTH = 64);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] read_data_1;
   logic [WIDTH-1:0] reg_mux;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             div_by_zero;
   logic             illegal_op;
   alu_state_e       dbg_state;

   modport master (
      output in_valid, opcode, read_data_1, reg_mux, out_ready,
      input  in_ready, out_valid, result, result_hi, zero, div_by_zero,
             illegal_op, dbg_state
   );

   modport slave (
      input  in_valid, opcode, read_data_1, reg_mux, out_ready,
      output in_ready, out_valid, result, result_hi, zero, div_by_zero,
             illegal_op, dbg_state
   );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// A single 2*WIDTH register is shared: for MUL it holds {partial, multiplier},
// for DIV it holds {remainder, dividend/quotient}.
// Ports: clk, reset (sync, active-low), start (load operands), is_div,
//        a, b (operands) -> done (last step this cycle), lo, hi (results).
// lo/hi are valid once the counter has reached zero and stay put until
// the next start.
module alu_iter_muldiv #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   b_q;
   logic               div_q;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_ext;
   logic [WIDTH-1:0]   rem_sub;

   always_comb begin
      // MUL: add multiplicand into the upper half when the current
      // multiplier bit is set, then shift right keeping the carry.
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
      // DIV: remainder shifted left with the next dividend bit; one extra
      // bit is needed because the shifted remainder can reach 2*b-1.
      rem_ext = acc[2*WIDTH-1:WIDTH-1];
      // Only used when rem_ext >= b, so the true difference fits WIDTH bits.
      rem_sub = rem_ext[WIDTH-1:0] - b_q;
      if (div_q) begin
         if (rem_ext >= {1'b0, b_q}) begin
            acc_step = {rem_sub, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc   <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt   <= '0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, a};
         b_q   <= b;
         div_q <= is_div;
         cnt   <= CNT_W'(WIDTH);
      end else if (cnt != '0) begin
         acc <= acc_step;
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Asserted during the cycle whose edge performs the final step.
   assign done = (cnt == CNT_W'(1));
   assign lo   = acc[WIDTH-1:0];
   assign hi   = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// ADD/SUB/AND/OR, illegal opcodes and divide-by-zero finish one cycle after
// accept; MUL and DIV iterate one bit per cycle (WIDTH+1 cycles latency).
// Ports: clk, reset (sync, active-low), bus (seq_alu_if.slave): request
//        in_valid/in_ready/opcode/read_data_1/reg_mux, response
//        out_valid/out_ready/result/result_hi/zero/div_by_zero/illegal_op,
//        plus dbg_state exposing the FSM state.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic   clk,
   input  logic   reset,
   seq_alu_if.slave bus
);

   alu_state_e       state, state_next;
   logic             accept;
   logic             iter_op;
   logic             start;
   logic             iter_done;
   logic [WIDTH-1:0] iter_lo, iter_hi;
   logic [WIDTH-1:0] sc_lo, sc_hi;

   logic [WIDTH-1:0] res_q, hi_q;
   logic             use_iter_q, zero_q, dbz_q, ill_q;

   assign accept  = bus.in_valid && bus.in_ready;
   assign iter_op = (bus.opcode == OP_MUL) ||
                    ((bus.opcode == OP_DIV) && (bus.reg_mux != '0));

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (iter_op) begin
                  state_next = ST_BUSY;
                  start      = 1'b1;
               end else begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_BUSY: if (iter_done) state_next = ST_DONE;
         ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Single-cycle datapath; MUL and non-zero DIV are taken by the iterator.
   always_comb begin
      sc_lo = '0;
      sc_hi = '0;
      case (bus.opcode)
         OP_ADD: sc_lo = bus.read_data_1 + bus.reg_mux;
         OP_SUB: sc_lo = bus.read_data_1 - bus.reg_mux;
         OP_AND: sc_lo = bus.read_data_1 & bus.reg_mux;
         OP_OR:  sc_lo = bus.read_data_1 | bus.reg_mux;
         OP_DIV: begin
            if (bus.reg_mux == '0) begin
               sc_lo = '1;
               sc_hi = bus.read_data_1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         res_q      <= '0;
         hi_q       <= '0;
         use_iter_q <= 1'b0;
         zero_q     <= 1'b0;
         dbz_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else if (accept) begin
         res_q      <= sc_lo;
         hi_q       <= sc_hi;
         use_iter_q <= iter_op;
         zero_q     <= (bus.read_data_1 == bus.reg_mux);
         dbz_q      <= (bus.opcode == OP_DIV) && (bus.reg_mux == '0);
         ill_q      <= !is_legal_op(bus.opcode);
      end
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .is_div (bus.opcode == OP_DIV),
      .a      (bus.read_data_1),
      .b      (bus.reg_mux),
      .done   (iter_done),
      .lo     (iter_lo),
      .hi     (iter_hi)
   );

   // in_ready is forced low while reset is asserted, even if already idle.
   assign bus.in_ready    = reset && (state == ST_IDLE);
   assign bus.out_valid   = (state == ST_DONE);
   assign bus.result      = bus.out_valid ? (use_iter_q ? iter_lo : res_q) : '0;
   assign bus.result_hi   = bus.out_valid ? (use_iter_q ? iter_hi : hi_q) : '0;
   assign bus.zero        = bus.out_valid && zero_q;
   assign bus.div_by_zero = bus.out_valid && dbz_q;
   assign bus.illegal_op  = bus.out_valid && ill_q;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: one WIDTH=64 and one WIDTH=8 instance on a shared
// clock and reset, checked against an arithmetic reference model.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(64)) if64 ();
   seq_alu_if #(.WIDTH(8))  if8 ();

   seq_alu #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));
   seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

   typedef struct {
      logic [63:0] res;
      logic [63:0] hi;
      logic        z;
      logic        dbz;
      logic        ill;
      int          lat;
   } exp_t;

   // Reference model: plain arithmetic on the operand values.
   function automatic exp_t ref_model(input int w, input logic [3:0] op,
                                      input logic [63:0] a, input logic [63:0] b);
      exp_t         e;
      logic [63:0]  mask;
      logic [127:0] prod, prod_hi;
      mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      e.res = '0; e.hi = '0; e.z = (a == b); e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
      case (op)
         4'b0010: e.res = (a + b) & mask;
         4'b0110: e.res = (a - b) & mask;
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b1000: begin
            prod    = {64'd0, a} * {64'd0, b};
            prod_hi = prod >> w;
            e.res   = prod[63:0] & mask;
            e.hi    = prod_hi[63:0] & mask;
            e.lat   = w + 1;
         end
         4'b0011: begin
            if (b == 64'd0) begin
               e.res = mask; e.hi = a; e.dbz = 1'b1;
            end else begin
               e.res = a / b; e.hi = a % b; e.lat = w + 1;
            end
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic [3:0] pick_op();
      logic [3:0] tab [6] = '{4'b0010, 4'b0110, 4'b1000, 4'b0011, 4'b0000, 4'b0001};
      int k = $urandom_range(0, 7);
      if (k < 6) return tab[k];
      return 4'($urandom);
   endfunction

   function automatic logic [63:0] pick_b(input logic [63:0] a, input logic [63:0] mask);
      int m = $urandom_range(0, 7);
      if (m == 0) return a;
      if (m == 1) return 64'd0;
      if (m == 2) return 64'($urandom_range(1, 15));
      return {$urandom, $urandom} & mask;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic run64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output logic [63:0] rh,
                        output logic z, output logic d, output logic il,
                        output int lat, output bit ready_seen, output bit timed_out);
      int n;
      timed_out = 1'b0; ready_seen = 1'b0;
      @(negedge clk);
      if64.in_valid = 1'b1; if64.opcode = op; if64.read_data_1 = a; if64.reg_mux = b;
      n = 0;
      while (!if64.in_ready && n < 200) begin @(negedge clk); n++; end
      if (!if64.in_ready) timed_out = 1'b1;
      @(negedge clk);
      // Scramble inputs after accept: the captured operands must be used.
      if64.in_valid = 1'b0; if64.opcode = 4'($urandom);
      if64.read_data_1 = {$urandom, $urandom}; if64.reg_mux = {$urandom, $urandom};
      lat = 1;
      while (!if64.out_valid && lat < 200) begin
         if (if64.in_ready) ready_seen = 1'b1;
         @(negedge clk); lat++;
      end
      if (!if64.out_valid) timed_out = 1'b1;
      if (if64.in_ready) ready_seen = 1'b1;
      r = if64.result; rh = if64.result_hi;
      z = if64.zero; d = if64.div_by_zero; il = if64.illegal_op;
   endtask

   task automatic release64();
      if64.out_ready = 1'b1;
      @(negedge clk);
      if64.out_ready = 1'b0;
   endtask

   task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [7:0] rh,
                       output logic z, output logic d, output logic il,
                       output int lat, output bit timed_out);
      int n;
      timed_out = 1'b0;
      @(negedge clk);
      if8.in_valid = 1'b1; if8.opcode = op; if8.read_data_1 = a; if8.reg_mux = b;
      n = 0;
      while (!if8.in_ready && n < 200) begin @(negedge clk); n++; end
      if (!if8.in_ready) timed_out = 1'b1;
      @(negedge clk);
      if8.in_valid = 1'b0; if8.opcode = 4'($urandom);
      if8.read_data_1 = 8'($urandom); if8.reg_mux = 8'($urandom);
      lat = 1;
      while (!if8.out_valid && lat < 200) begin @(negedge clk); lat++; end
      if (!if8.out_valid) timed_out = 1'b1;
      r = if8.result; rh = if8.result_hi;
      z = if8.zero; d = if8.div_by_zero; il = if8.illegal_op;
   endtask

   task automatic release8();
      if8.out_ready = 1'b1;
      @(negedge clk);
      if8.out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (if64.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready64 got=%b want=0", if64.in_ready); end
      total++; if (if8.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready8 got=%b want=0", if8.in_ready); end
      total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", if64.out_valid); end
      total++; if (if64.result !== 64'd0 || if64.result_hi !== 64'd0) begin
         bad++; $display("FAIL reset_result got=%h/%h want=0/0", if64.result, if64.result_hi); end
      total++; if ({if64.zero, if64.div_by_zero, if64.illegal_op} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {if64.zero, if64.div_by_zero, if64.illegal_op}); end
      total++; if (if64.dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", if64.dbg_state, ST_IDLE); end
      reset = 1'b1;
      #1;
      total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", if64.in_ready); end
   endtask

   task automatic test_single_cycle();
      logic [3:0]  ops [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111};
      logic [63:0] as  [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'hF0, 64'hF0, 64'h55};
      logic [63:0] bs  [5] = '{64'd1, 64'h1234, 64'h3C, 64'h3C, 64'h55};
      logic [63:0] r, rh; logic z, d, il; int lat; bit rs, to; exp_t e;
      for (int i = 0; i < 5; i++) begin
         e = ref_model(64, ops[i], as[i], bs[i]);
         run64(ops[i], as[i], bs[i], r, rh, z, d, il, lat, rs, to);
         total++; if (to) begin bad++; $display("FAIL sc_timeout op=%b got=timeout want=done", ops[i]); end
         total++; if (r !== e.res || rh !== e.hi) begin
            bad++; $display("FAIL sc_result op=%b got=%h/%h want=%h/%h", ops[i], rh, r, e.hi, e.res); end
         total++; if ({z, d, il} !== {e.z, e.dbz, e.ill}) begin
            bad++; $display("FAIL sc_flags op=%b got=%b want=%b", ops[i], {z, d, il}, {e.z, e.dbz, e.ill}); end
         total++; if (lat != 1) begin bad++; $display("FAIL sc_latency op=%b got=%0d want=1", ops[i], lat); end
         release64();
      end
   endtask

   task automatic test_mul64();
      logic [63:0] r, rh; logic z, d, il; int lat; bit rs, to; exp_t e;
      e = ref_model(64, OP_MUL, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      run64(OP_MUL, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, rh, z, d, il, lat, rs, to);
      total++; if (to) begin bad++; $display("FAIL mul_timeout got=timeout want=done"); end
      total++; if (r !== e.res || rh !== e.hi) begin
         bad++; $display("FAIL mul_result got=%h/%h want=%h/%h", rh, r, e.hi, e.res); end
      total++; if (lat != 65) begin bad++; $display("FAIL mul_latency got=%0d want=65", lat); end
      total++; if (rs) begin bad++; $display("FAIL mul_in_ready got=1 want=0 while busy"); end
      total++; if (z !== 1'b1) begin bad++; $display("FAIL mul_zero got=%b want=1", z); end
      release64();
   endtask

   task automatic test_div8();
      logic [7:0] r, rh; logic z, d, il; int lat; bit to;
      run8(OP_DIV, 8'd200, 8'd7, r, rh, z, d, il, lat, to);
      total++; if (to) begin bad++; $display("FAIL div8_timeout got=timeout want=done"); end
      total++; if (r !== 8'd28 || rh !== 8'd4) begin bad++; $display("FAIL div8_result got=%0d r%0d want=28 r4", r, rh); end
      total++; if (lat != 9) begin bad++; $display("FAIL div8_latency got=%0d want=9", lat); end
      release8();
      run8(OP_DIV, 8'd5, 8'd0, r, rh, z, d, il, lat, to);
      total++; if (r !== 8'hFF || rh !== 8'd5) begin bad++; $display("FAIL div0_result got=%h/%h want=ff/05", r, rh); end
      total++; if (d !== 1'b1 || il !== 1'b0) begin bad++; $display("FAIL div0_flags got=%b%b want=10", d, il); end
      total++; if (lat != 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
      release8();
   endtask

   task automatic test_random64(input int n_ops);
      exp_t exp_q[$]; exp_t e;
      logic [63:0] a, b, r, rh; logic [3:0] op; logic z, d, il; int lat; bit rs, to;
      for (int i = 0; i < n_ops; i++) begin
         op = pick_op(); a = {$urandom, $urandom}; b = pick_b(a, {64{1'b1}});
         exp_q.push_back(ref_model(64, op, a, b));
         run64(op, a, b, r, rh, z, d, il, lat, rs, to);
         e = exp_q.pop_front();
         total++; if (to) begin bad++; $display("FAIL rnd64_timeout i=%0d got=timeout want=done", i); end
         total++; if (r !== e.res) begin bad++; $display("FAIL rnd64_result i=%0d op=%b a=%h b=%h got=%h want=%h", i, op, a, b, r, e.res); end
         total++; if (rh !== e.hi) begin bad++; $display("FAIL rnd64_hi i=%0d op=%b a=%h b=%h got=%h want=%h", i, op, a, b, rh, e.hi); end
         total++; if ({z, d, il} !== {e.z, e.dbz, e.ill}) begin
            bad++; $display("FAIL rnd64_flags i=%0d op=%b got=%b want=%b", i, op, {z, d, il}, {e.z, e.dbz, e.ill}); end
         total++; if (lat != e.lat) begin bad++; $display("FAIL rnd64_latency i=%0d op=%b got=%0d want=%0d", i, op, lat, e.lat); end
         total++; if (rs) begin bad++; $display("FAIL rnd64_in_ready i=%0d got=1 want=0 before release", i); end
         release64();
      end
   endtask

   task automatic test_random8(input int n_ops);
      exp_t exp_q[$]; exp_t e;
      logic [63:0] a, b; logic [7:0] r, rh; logic [3:0] op; logic z, d, il; int lat; bit to;
      for (int i = 0; i < n_ops; i++) begin
         op = pick_op(); a = 64'($urandom_range(0, 255)); b = pick_b(a, 64'hFF);
         exp_q.push_back(ref_model(8, op, a, b));
         run8(op, a[7:0], b[7:0], r, rh, z, d, il, lat, to);
         e = exp_q.pop_front();
         total++; if (to) begin bad++; $display("FAIL rnd8_timeout i=%0d got=timeout want=done", i); end
         total++; if (r !== e.res[7:0] || rh !== e.hi[7:0]) begin
            bad++; $display("FAIL rnd8_result i=%0d op=%b a=%0d b=%0d got=%h/%h want=%h/%h", i, op, a, b, rh, r, e.hi[7:0], e.res[7:0]); end
         total++; if ({z, d, il} !== {e.z, e.dbz, e.ill}) begin
            bad++; $display("FAIL rnd8_flags i=%0d op=%b got=%b want=%b", i, op, {z, d, il}, {e.z, e.dbz, e.ill}); end
         total++; if (lat != e.lat) begin bad++; $display("FAIL rnd8_latency i=%0d op=%b got=%0d want=%0d", i, op, lat, e.lat); end
         release8();
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] a, b, r, rh; logic z, d, il; int lat; bit rs, to; exp_t e;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      e = ref_model(64, OP_MUL, a, b);
      run64(OP_MUL, a, b, r, rh, z, d, il, lat, rs, to);
      total++; if (r !== e.res || rh !== e.hi) begin
         bad++; $display("FAIL bp_result got=%h/%h want=%h/%h", rh, r, e.hi, e.res); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++; if (if64.out_valid !== 1'b1 || if64.result !== e.res || if64.result_hi !== e.hi) begin
            bad++; $display("FAIL bp_hold cyc=%0d got=v%b %h/%h want=v1 %h/%h", i, if64.out_valid, if64.result_hi, if64.result, e.hi, e.res); end
         total++; if (if64.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, if64.in_ready); end
      end
      if64.out_ready = 1'b1;
      @(negedge clk);
      if64.out_ready = 1'b0;
      total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", if64.out_valid); end
      total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%b want=1", if64.in_ready); end
      total++; if (if64.result !== 64'd0) begin bad++; $display("FAIL bp_idle_result got=%h want=0", if64.result); end
   endtask

   task automatic test_reset_mid_div();
      logic [7:0] r, rh; logic z, d, il; int lat; bit to; int seen;
      @(negedge clk);
      total++; if (if8.in_ready !== 1'b1) begin bad++; $display("FAIL mid_start_ready got=%b want=1", if8.in_ready); end
      if8.in_valid = 1'b1; if8.opcode = OP_DIV; if8.read_data_1 = 8'd200; if8.reg_mux = 8'd7;
      @(negedge clk);
      if8.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (if8.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", if8.out_valid); end
      total++; if (if8.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", if8.in_ready); end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (if8.out_valid) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL mid_ghost_valid got=%0d want=0", seen); end
      run8(OP_ADD, 8'd2, 8'd3, r, rh, z, d, il, lat, to);
      total++; if (to || r !== 8'd5 || rh !== 8'd0) begin bad++; $display("FAIL mid_add got=%0d/%0d want=0/5", rh, r); end
      release8();
      run8(4'b1111, 8'd9, 8'd4, r, rh, z, d, il, lat, to);
      total++; if (to || il !== 1'b1 || r !== 8'd0 || rh !== 8'd0) begin
         bad++; $display("FAIL illegal got=ill%b %h/%h want=ill1 00/00", il, rh, r); end
      total++; if (lat != 1) begin bad++; $display("FAIL illegal_latency got=%0d want=1", lat); end
      release8();
   endtask

   initial begin
      if64.in_valid = 1'b0; if64.out_ready = 1'b0; if64.opcode = '0;
      if64.read_data_1 = '0; if64.reg_mux = '0;
      if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.opcode = '0;
      if8.read_data_1 = '0; if8.reg_mux = '0;
      test_reset();
      test_single_cycle();
      test_mul64();
      test_div8();
      test_backpressure();
      test_random64(40);
      test_random8(40);
      test_reset_mid_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=no_finish want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
